uart_tx_peripheral: RTL and testbench

- Memory-mapped UART transmitter. It is a responder on a 4-bit peripheral port of the memory controller, using the same we/addr/in/out convention as the LED, switch and VGA peripherals.
- CPU writes bytes into a TX FIFO. A bit-serial engine drains the FIFO onto the tx pin as 8N1 frames at a programmable divisor.
- Sits at peripheral window 0x1040–0x104F; the controller-side decode is added separately.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_peripheral_fifo.sv | 38 +++
 rtl/uart_tx_peripheral.sv | 150 +++++++++++++++
 tb/tb_uart_tx_peripheral.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register offsets, STATUS/CONTROL bit positions and TX FSM states.
package uart_tx_pkg;
    localparam logic [3:0] REG_DATA    = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h1;
    localparam logic [3:0] REG_DIVISOR = 4'h2;
    localparam logic [3:0] REG_CONTROL = 4'h3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_COUNT = 8;

    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_CLR_OVF = 2;
    localparam int CTRL_ODD     = 3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
endpackage

// File: rtl/uart_tx_peripheral_fifo.sv
// tx_fifo: single-clock byte FIFO; pushes on full and pops on empty are ignored, head shown combinationally.
module tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral: memory-mapped 8N1 UART transmitter with TX FIFO and programmable divisor.
// Define UART_TX_PARITY_EN to add an even/odd parity bit (CONTROL[3] selects odd).
module uart_tx_peripheral
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_p_we,
    input  logic [3:0]  uart_p_addr,
    input  logic [31:0] uart_p_in,
    output logic [31:0] uart_p_out,
    output logic        tx,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif
    state_t state, state_n;
    logic [DIV_W-1:0] divisor, div_lat, div_lat_n, baud, baud_n;
    logic [7:0] shift, shift_n, fifo_dout;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [CW-1:0] count;
    logic [31:0] status, control, rd_data;
    logic tx_en, irq_en, odd, overflow, full, empty, pop, wr_data, baud_done;
    logic unused_in;

    assign unused_in = ^uart_p_in[31:DIV_W];
    assign wr_data = uart_p_we && uart_p_addr == REG_DATA;
    assign baud_done = baud == '0;
    assign irq = empty && state == S_IDLE && irq_en;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (pop),
        .din   (uart_p_in[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            divisor <= DIV_W'(DEFAULT_DIV);
            tx_en <= 1'b0;
            irq_en <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_data && full) overflow <= 1'b1;
            if (uart_p_we && uart_p_addr == REG_DIVISOR) divisor <= uart_p_in[DIV_W-1:0];
            if (uart_p_we && uart_p_addr == REG_CONTROL) begin
                tx_en <= uart_p_in[CTRL_TX_EN];
                irq_en <= uart_p_in[CTRL_IRQ_EN];
                if (uart_p_in[CTRL_CLR_OVF]) overflow <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    logic par;
    always_ff @(posedge clk) begin
        if (rst) begin
            odd <= 1'b0;
            par <= 1'b0;
        end else begin
            if (uart_p_we && uart_p_addr == REG_CONTROL) odd <= uart_p_in[CTRL_ODD];
            if (pop) par <= ^fifo_dout ^ odd;
        end
    end
    assign tx = state == S_START ? 1'b0 : state == S_DATA ? shift[0] : state == S_PARITY ? par : 1'b1;
`else
    assign odd = 1'b0;
    assign tx = state == S_START ? 1'b0 : state == S_DATA ? shift[0] : 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            shift <= '0;
            bit_cnt <= '0;
            baud <= '0;
            div_lat <= DIV_W'(1);
        end else begin
            state <= state_n;
            shift <= shift_n;
            bit_cnt <= bit_cnt_n;
            baud <= baud_n;
            div_lat <= div_lat_n;
        end
    end

    // div_lat is captured at frame start so divisor writes only affect the next frame
    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_cnt_n = bit_cnt;
        div_lat_n = div_lat;
        pop = 1'b0;
        baud_n = state == S_IDLE ? baud : baud_done ? div_lat - 1'b1 : baud - 1'b1;
        case (state)
            S_IDLE: if (tx_en && !empty) begin
                pop = 1'b1;
                shift_n = fifo_dout;
                div_lat_n = divisor == '0 ? DIV_W'(1) : divisor;
                baud_n = div_lat_n - 1'b1;
                bit_cnt_n = '0;
                state_n = S_START;
            end
            S_START: state_n = baud_done ? S_DATA : S_START;
            S_DATA: if (baud_done) begin
                shift_n = shift >> 1;
                bit_cnt_n = bit_cnt + 1'b1;
                state_n = bit_cnt == 3'd7 ? AFTER_DATA : S_DATA;
            end
            S_PARITY: state_n = baud_done ? S_STOP : S_PARITY;
            S_STOP: state_n = baud_done ? S_IDLE : S_STOP;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        status = '0;
        status[ST_BUSY] = state != S_IDLE;
        status[ST_FULL] = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF] = overflow;
        status[ST_COUNT+:5] = 5'(count);
        control = '0;
        control[CTRL_TX_EN] = tx_en;
        control[CTRL_IRQ_EN] = irq_en;
        control[CTRL_ODD] = odd;
        rd_data = uart_p_addr == REG_STATUS ? status :
                  uart_p_addr == REG_DIVISOR ? 32'(divisor) :
                  uart_p_addr == REG_CONTROL ? control : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) uart_p_out <= '0;
        else uart_p_out <= rd_data;
    end
endmodule

// File: tb/tb_uart_tx_peripheral.sv
// tb_uart_tx_peripheral: directed self-checking bench for uart_tx_peripheral (default build, no parity).
module tb_uart_tx_peripheral;
    logic clk, rst, we, tx, irq;
    logic [3:0] addr;
    logic [31:0] din, dout, rv;
    int checks = 0;
    int failures = 0;
    logic [7:0] frames [3];

    uart_tx_peripheral dut (
        .clk         (clk),
        .rst         (rst),
        .uart_p_we   (we),
        .uart_p_addr (addr),
        .uart_p_in   (din),
        .uart_p_out  (dout),
        .tx          (tx),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1;
        addr = a;
        din = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        we = 1'b0;
        @(negedge clk);
        d = dout;
    endtask

    // Expected line level p clocks into an 8N1 frame of byte b at d clocks per bit
    function automatic logic exp_bit(input int p, input int d, input logic [7:0] b);
        int seg;
        seg = p / d;
        return p >= 10 * d ? 1'b1 : seg == 0 ? 1'b0 : seg <= 8 ? b[seg-1] : 1'b1;
    endfunction

    initial begin
        rst = 1'b1;
        we = 1'b0;
        addr = '0;
        din = '0;
        frames[0] = 8'hA5;
        frames[1] = 8'h3C;
        frames[2] = 8'h01;
        repeat (3) @(negedge clk);
        check("rst_out", dout, 32'h0);
        check("rst_tx", tx, 1);
        check("rst_irq", irq, 0);
        rst = 1'b0;
        rd(4'h1, rv); check("rst_status", rv, 32'h4);
        rd(4'h2, rv); check("rst_div", rv, 868);
        rd(4'h3, rv); check("rst_ctrl", rv, 0);
        rd(4'h0, rv); check("data_rd", rv, 0);
        rd(4'h7, rv); check("unmapped_rd", rv, 0);
        wr(4'hF, 32'hFFFF_FFFF);
        wr(4'h1, 32'hFFFF_FFFF);
        rd(4'h3, rv); check("unmapped_wr_ctrl", rv, 0);
        rd(4'h1, rv); check("status_wr_ignored", rv, 32'h4);

        // single frame 0x55 at 4 clk/bit
        wr(4'h2, 4);
        wr(4'h3, 1);
        rd(4'h3, rv); check("ctrl_rb", rv, 1);
        wr(4'h0, 32'h55);
        check("t2_pre_tx", tx, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("t2_tx", tx, exp_bit(i, 4, 8'h55));
            if (i == 20) begin
                addr = 4'h1;
                @(negedge clk);
                i++;
                check("t2_busy", dout[0], 1);
                check("t2_tx", tx, exp_bit(i, 4, 8'h55));
            end
        end
        rd(4'h1, rv); check("t2_idle_status", rv, 32'h4);

        // overflow with transmitter disabled
        wr(4'h3, 0);
        for (int i = 0; i < 17; i++) wr(4'h0, i);
        rd(4'h1, rv); check("t3_full_ovf", rv, 32'h100A);
        wr(4'h3, 4);
        rd(4'h1, rv); check("t3_ovf_clr", rv, 32'h1002);
        rd(4'h3, rv); check("t3_ctrl_rb", rv, 0);
        check("t3_tx", tx, 1);

        // three back-to-back frames at 2 clk/bit with irq enabled
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wr(4'h2, 2);
        for (int i = 0; i < 3; i++) wr(4'h0, frames[i]);
        check("t4_irq_off", irq, 0);
        rd(4'h1, rv); check("t4_queued", rv, 32'h300);
        wr(4'h3, 3);
        for (int i = 0; i < 63; i++) begin
            @(negedge clk);
            check("t4_tx", tx, exp_bit(i % 21, 2, frames[i / 21]));
            check("t4_irq", irq, i == 62);
        end
        rd(4'h1, rv); check("t4_done_status", rv, 32'h4);
        check("t4_irq_hold", irq, 1);
        wr(4'h3, 1);
        check("t4_irq_masked", irq, 0);

        // divisor change mid-frame only affects the next frame
        wr(4'h3, 0);
        wr(4'h2, 3);
        wr(4'h0, 32'h0F);
        wr(4'h0, 32'hF0);
        wr(4'h3, 1);
        for (int i = 0; i < 112; i++) begin
            @(negedge clk);
            if (i == 3) begin
                we = 1'b1;
                addr = 4'h2;
                din = 8;
            end
            if (i == 4) we = 1'b0;
            check("t5_tx", tx, i < 31 ? exp_bit(i, 3, 8'h0F) : exp_bit(i - 31, 8, 8'hF0));
        end
        wr(4'h2, 0);
        wr(4'h0, 32'hC3);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("t5_div0_tx", tx, exp_bit(i, 1, 8'hC3));
        end
        rd(4'h2, rv); check("t5_div0_rb", rv, 0);

        // reset during DATA bit 3
        wr(4'h2, 4);
        wr(4'h0, 32'h96);
        wr(4'h0, 32'h69);
        check("t6_start", tx, 0);
        repeat (15) @(negedge clk);
        check("t6_bit3", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_tx", tx, 1);
        check("t6_rst_out", dout, 0);
        rst = 1'b0;
        check("t6_irq", irq, 0);
        rd(4'h1, rv); check("t6_status", rv, 32'h4);
        rd(4'h2, rv); check("t6_div", rv, 868);
        for (int i = 0; i < 3; i++) wr(4'h0, 32'h10 + i);
        for (int i = 0; i < 3; i++) begin
            rd(4'h0, rv); check("t6_rd_data", rv, 0);
            rd(4'h1, rv); check("t6_rd_status", rv, 32'h300);
        end
        check("t6_tx_idle", tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
